controle_partida: RTL and testbench
===================================

CONTROLE_PARTIDA -- requirements
Module: controle_partida

Interface
REQ-001 Parameter TOTAL_ACERTOS, default 10: number of hit ship cells that wins a match (range 1..31).
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait for col_ready per shot (range 1..255).
REQ-003 clk  in  1  the block's single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high; has priority over every other input.
REQ-005 on  in  1  game power switch (SW0); 0 forces the power-off state.
REQ-006 mode  in  1  game mode (SW1); sampled only when leaving the power-off state.
REQ-007 pos_ready  in  1  one-cycle pulse: ship placement for pos_jogador is complete.
REQ-008 tiro_valid  in  1  one-cycle pulse: shot request with coordinates on tiro_x/tiro_y.
REQ-009 tiro_x, tiro_y  in  3 each  shot coordinates on the 8x8 board.
REQ-010 col_ready  in  1  one-cycle pulse: the collision checker has finished.
REQ-011 col_hit  in  1  collision result; valid only while col_ready=1.
REQ-012 pos_enable  out  1  enables the placement unit.
REQ-013 pos_jogador  out  1  player whose ships are being placed (0=P1, 1=P2).
REQ-014 jogo_enable  out  1  enables shot entry.
REQ-015 col_enable  out  1  one-cycle start pulse to the collision checker.
REQ-016 col_x, col_y  out  3 each  latched shot coordinates.
REQ-017 col_jogador  out  1  target player (the player who is not shooting).
REQ-018 jogador_vez  out  1  player currently shooting.
REQ-019 acertos_p1, acertos_p2  out  5 each  hits scored by each player.
REQ-020 fim  out  1  match over.
REQ-021 vencedor  out  1  winner; valid only while fim=1.
REQ-022 erro_timeout  out  1  sticky flag: a collision check timed out.
REQ-023 estado  out  3  current state encoding, for debug.

Function
REQ-024 The controller SHALL be a Moore FSM with these states and encodings: DESLIGADO=0, POS_P1=1, POS_P2=2, AGUARDA_TIRO=3, COLISAO=4, FIM=5.
REQ-025 If on=0 and reset=0, the state SHALL become DESLIGADO on the next edge, from any state; counters and flags SHALL keep their values.
REQ-026 From DESLIGADO with on=1, the FSM SHALL go to POS_P1, latch mode, clear both hit counters, clear erro_timeout, and set jogador_vez=0.
REQ-027 In POS_P1, the outputs SHALL be pos_enable=1 and pos_jogador=0; pos_ready SHALL move the FSM to POS_P2.
REQ-028 In POS_P2, the outputs SHALL be pos_enable=1 and pos_jogador=1; pos_ready SHALL move the FSM to AGUARDA_TIRO.
REQ-029 pos_ready outside POS_P1 and POS_P2 SHALL be ignored.
REQ-030 In AGUARDA_TIRO, jogo_enable SHALL be 1.
REQ-031 On tiro_valid in AGUARDA_TIRO, the controller SHALL latch tiro_x/tiro_y into col_x/col_y, assert col_enable for exactly the next cycle, and enter COLISAO.
REQ-032 tiro_valid in any state other than AGUARDA_TIRO SHALL be ignored.
REQ-033 In COLISAO, a wait counter SHALL count cycles; col_ready SHALL end the wait.
REQ-034 If col_ready=1 with col_hit=1, the shooter's counter SHALL increment by 1, saturating at TOTAL_ACERTOS.
REQ-035 If the incremented count equals TOTAL_ACERTOS, the FSM SHALL enter FIM with vencedor=jogador_vez.
REQ-036 Turn rule, mode latched 0: jogador_vez SHALL toggle after every resolved shot.
REQ-037 Turn rule, mode latched 1: a hit SHALL keep the turn and a miss SHALL toggle it.
REQ-038 After a resolved shot that does not end the match, the FSM SHALL return to AGUARDA_TIRO.
REQ-039 If TIMEOUT cycles pass in COLISAO without col_ready, the shot SHALL be treated as a miss, erro_timeout SHALL be set, and the FSM SHALL return to AGUARDA_TIRO.
REQ-040 If col_ready arrives on the same cycle the timeout expires, col_ready SHALL win.
REQ-041 col_jogador SHALL always equal the inverse of jogador_vez.
REQ-042 FIM SHALL hold fim=1 with all enables at 0 until reset=1 or on=0.
REQ-043 Counter widths: 5 bits for hits and 8 bits for the wait counter; no wrap-around is permitted.

Reset
REQ-044 On reset, the state SHALL be DESLIGADO and all outputs SHALL be 0, including counters, flags, col_x/col_y and the latched mode; this applies mid-shot or mid-placement as well.

Verification
REQ-045 on=1, then pos_ready twice -> estado sequence 0,1,2,3; pos_jogador goes 0 then 1; jogo_enable=1.
REQ-046 mode=0, P1 shot at (3,5), col_ready with col_hit=1 two cycles after col_enable -> acertos_p1=1, jogador_vez=1, col_x=3, col_y=5.
REQ-047 mode=1, P1 scores a hit -> jogador_vez stays 0; a following miss -> jogador_vez=1.
REQ-048 TOTAL_ACERTOS=2, P2 scores its 2nd hit -> fim=1, vencedor=1, estado=5; further tiro_valid is ignored.
REQ-049 col_ready is never returned -> after 15 cycles the FSM is back in AGUARDA_TIRO, erro_timeout=1, turn toggled, counters unchanged.
REQ-050 reset in COLISAO, or on=0 in POS_P2 -> estado=0 on the next cycle; after reset, all outputs are 0.

Source files
------------

// File: rtl/controle_partida.sv
// Match controller for a two-player battleship game on an 8x8 board.
// Sequences ship placement for both players, then alternates shots, hands
// each shot to an external collision checker and keeps the score. The
// collision wait is bounded: an unanswered check counts as a miss and
// raises a sticky error flag.
module controle_partida #(
    parameter int TOTAL_ACERTOS = 10,
    parameter int TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on,
    input  logic       mode,
    input  logic       pos_ready,
    input  logic       tiro_valid,
    input  logic [2:0] tiro_x,
    input  logic [2:0] tiro_y,
    input  logic       col_ready,
    input  logic       col_hit,
    output logic       pos_enable,
    output logic       pos_jogador,
    output logic       jogo_enable,
    output logic       col_enable,
    output logic [2:0] col_x,
    output logic [2:0] col_y,
    output logic       col_jogador,
    output logic       jogador_vez,
    output logic [4:0] acertos_p1,
    output logic [4:0] acertos_p2,
    output logic       fim,
    output logic       vencedor,
    output logic       erro_timeout,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        DESLIGADO    = 3'd0,
        POS_P1       = 3'd1,
        POS_P2       = 3'd2,
        AGUARDA_TIRO = 3'd3,
        COLISAO      = 3'd4,
        FIM          = 3'd5
    } state_t;

    localparam logic [4:0] ALVO      = 5'(TOTAL_ACERTOS);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] wait_reg;
    logic       mode_reg;

    // Shooter's score after a hit, held at the winning value so it never wraps.
    logic [4:0] cnt_shooter;
    logic [4:0] cnt_hit;
    logic       wins;

    // Score of the current shooter, the value a hit would give, and whether that hit ends the match.
    always_comb begin
        cnt_shooter = jogador_vez ? acertos_p2 : acertos_p1;
        cnt_hit     = (cnt_shooter >= ALVO) ? ALVO : cnt_shooter + 5'd1;
        wins        = (cnt_hit == ALVO);
    end

    // Next-state selection; on=0 forces power-off from any state.
    always_comb begin
        state_next = state_reg;
        if (!on) begin
            state_next = DESLIGADO;
        end else begin
            case (state_reg)
                DESLIGADO:    state_next = POS_P1;
                POS_P1:       if (pos_ready) state_next = POS_P2;
                POS_P2:       if (pos_ready) state_next = AGUARDA_TIRO;
                AGUARDA_TIRO: if (tiro_valid) state_next = COLISAO;
                COLISAO: begin
                    if (col_ready)
                        state_next = (col_hit && wins) ? FIM : AGUARDA_TIRO;
                    else if (wait_reg >= WAIT_LAST)
                        state_next = AGUARDA_TIRO;
                end
                FIM:          state_next = FIM;
                default:      state_next = DESLIGADO;
            endcase
        end
    end

    assign estado = state_reg;

    // State, datapath and registered Moore outputs (decoded from the next state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= DESLIGADO;
            wait_reg     <= '0;
            mode_reg     <= 1'b0;
            pos_enable   <= 1'b0;
            pos_jogador  <= 1'b0;
            jogo_enable  <= 1'b0;
            col_enable   <= 1'b0;
            col_x        <= '0;
            col_y        <= '0;
            col_jogador  <= 1'b0;
            jogador_vez  <= 1'b0;
            acertos_p1   <= '0;
            acertos_p2   <= '0;
            fim          <= 1'b0;
            vencedor     <= 1'b0;
            erro_timeout <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pos_enable  <= (state_next == POS_P1) || (state_next == POS_P2);
            pos_jogador <= (state_next == POS_P2);
            jogo_enable <= (state_next == AGUARDA_TIRO);
            fim         <= (state_next == FIM);
            col_enable  <= 1'b0;

            if (on) begin
                case (state_reg)
                    DESLIGADO: begin
                        // New match: fresh scores, P1 shoots first. col_jogador
                        // is reset-cleared to 0 and tracks ~jogador_vez from here on.
                        mode_reg     <= mode;
                        acertos_p1   <= '0;
                        acertos_p2   <= '0;
                        erro_timeout <= 1'b0;
                        jogador_vez  <= 1'b0;
                        col_jogador  <= 1'b1;
                    end
                    AGUARDA_TIRO: begin
                        if (tiro_valid) begin
                            col_x      <= tiro_x;
                            col_y      <= tiro_y;
                            col_enable <= 1'b1;
                            wait_reg   <= '0;
                        end
                    end
                    COLISAO: begin
                        if (col_ready) begin
                            // A response on the expiry cycle still counts as a real result.
                            if (col_hit) begin
                                if (jogador_vez) acertos_p2 <= cnt_hit;
                                else             acertos_p1 <= cnt_hit;
                            end
                            if (col_hit && wins) begin
                                vencedor <= jogador_vez;
                            end else if (!mode_reg || !col_hit) begin
                                jogador_vez <= ~jogador_vez;
                                col_jogador <= jogador_vez;
                            end
                        end else if (wait_reg >= WAIT_LAST) begin
                            erro_timeout <= 1'b1;
                            jogador_vez  <= ~jogador_vez;
                            col_jogador  <= jogador_vez;
                        end else begin
                            wait_reg <= wait_reg + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controle_partida.sv
// Directed bench for controle_partida: placement, shots in both turn modes,
// collision timeout and its boundary, match end, power-off and reset.
module tb_controle_partida;

    logic       clk = 1'b0;
    logic       reset;
    logic       on;
    logic       mode;
    logic       pos_ready;
    logic       tiro_valid;
    logic [2:0] tiro_x;
    logic [2:0] tiro_y;
    logic       col_ready;
    logic       col_hit;
    logic       pos_enable;
    logic       pos_jogador;
    logic       jogo_enable;
    logic       col_enable;
    logic [2:0] col_x;
    logic [2:0] col_y;
    logic       col_jogador;
    logic       jogador_vez;
    logic [4:0] acertos_p1;
    logic [4:0] acertos_p2;
    logic       fim;
    logic       vencedor;
    logic       erro_timeout;
    logic [2:0] estado;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    controle_partida #(.TOTAL_ACERTOS(2), .TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .on           (on),
        .mode         (mode),
        .pos_ready    (pos_ready),
        .tiro_valid   (tiro_valid),
        .tiro_x       (tiro_x),
        .tiro_y       (tiro_y),
        .col_ready    (col_ready),
        .col_hit      (col_hit),
        .pos_enable   (pos_enable),
        .pos_jogador  (pos_jogador),
        .jogo_enable  (jogo_enable),
        .col_enable   (col_enable),
        .col_x        (col_x),
        .col_y        (col_y),
        .col_jogador  (col_jogador),
        .jogador_vez  (jogador_vez),
        .acertos_p1   (acertos_p1),
        .acertos_p2   (acertos_p2),
        .fim          (fim),
        .vencedor     (vencedor),
        .erro_timeout (erro_timeout),
        .estado       (estado)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".estado"}, 8'(estado), 8'd0);
        chk({tag, ".pos_enable"}, 8'(pos_enable), 8'd0);
        chk({tag, ".pos_jogador"}, 8'(pos_jogador), 8'd0);
        chk({tag, ".jogo_enable"}, 8'(jogo_enable), 8'd0);
        chk({tag, ".col_enable"}, 8'(col_enable), 8'd0);
        chk({tag, ".col_x"}, 8'(col_x), 8'd0);
        chk({tag, ".col_y"}, 8'(col_y), 8'd0);
        chk({tag, ".col_jogador"}, 8'(col_jogador), 8'd0);
        chk({tag, ".jogador_vez"}, 8'(jogador_vez), 8'd0);
        chk({tag, ".acertos_p1"}, 8'(acertos_p1), 8'd0);
        chk({tag, ".acertos_p2"}, 8'(acertos_p2), 8'd0);
        chk({tag, ".fim"}, 8'(fim), 8'd0);
        chk({tag, ".vencedor"}, 8'(vencedor), 8'd0);
        chk({tag, ".erro_timeout"}, 8'(erro_timeout), 8'd0);
    endtask

    // Shot request: one-cycle tiro_valid pulse.
    task automatic shoot(input logic [2:0] x, input logic [2:0] y);
        tiro_x = x; tiro_y = y; tiro_valid = 1'b1;
        step();
        tiro_valid = 1'b0;
        $display("shot (%0d,%0d) estado=%0d col_enable=%0d", x, y, estado, col_enable);
    endtask

    // Collision answer after 'idle' quiet cycles in COLISAO.
    task automatic answer(input int idle, input logic hit);
        for (int i = 0; i < idle; i++) step();
        col_ready = 1'b1; col_hit = hit;
        step();
        col_ready = 1'b0; col_hit = 1'b0;
        $display("answer hit=%0d estado=%0d vez=%0d p1=%0d p2=%0d", hit, estado, jogador_vez, acertos_p1, acertos_p2);
    endtask

    task automatic place();
        pos_ready = 1'b1;
        step();
        pos_ready = 1'b0;
        $display("pos_ready estado=%0d pos_jogador=%0d", estado, pos_jogador);
    endtask

    initial begin
        reset = 1'b1; on = 1'b0; mode = 1'b0; pos_ready = 1'b0; tiro_valid = 1'b0;
        tiro_x = '0; tiro_y = '0; col_ready = 1'b0; col_hit = 1'b0;
        step(); step();
        chk_zero("rst");
        reset = 1'b0;

        // Power on, mode 0: placement sequence 1,2,3
        on = 1'b1;
        step();
        chk("on.estado", 8'(estado), 8'd1);
        chk("on.pos_enable", 8'(pos_enable), 8'd1);
        chk("on.pos_jogador", 8'(pos_jogador), 8'd0);
        chk("on.col_jogador", 8'(col_jogador), 8'd1);
        place();
        chk("p2.estado", 8'(estado), 8'd2);
        chk("p2.pos_jogador", 8'(pos_jogador), 8'd1);
        shoot(3'd7, 3'd7);
        chk("p2.tiro_ignored", 8'(estado), 8'd2);
        chk("p2.no_col_enable", 8'(col_enable), 8'd0);
        place();
        chk("ag.estado", 8'(estado), 8'd3);
        chk("ag.jogo_enable", 8'(jogo_enable), 8'd1);
        chk("ag.pos_enable", 8'(pos_enable), 8'd0);
        place();
        chk("ag.pos_ready_ignored", 8'(estado), 8'd3);

        // P1 hits at (3,5), answer two cycles after col_enable
        shoot(3'd3, 3'd5);
        chk("s1.estado", 8'(estado), 8'd4);
        chk("s1.col_enable", 8'(col_enable), 8'd1);
        chk("s1.col_x", 8'(col_x), 8'd3);
        chk("s1.col_y", 8'(col_y), 8'd5);
        step();
        chk("s1.col_enable_one_cycle", 8'(col_enable), 8'd0);
        answer(0, 1'b1);
        chk("s1.estado_back", 8'(estado), 8'd3);
        chk("s1.acertos_p1", 8'(acertos_p1), 8'd1);
        chk("s1.vez", 8'(jogador_vez), 8'd1);
        chk("s1.col_jogador", 8'(col_jogador), 8'd0);

        // P2 shot never answered: 15 cycles in COLISAO then back
        shoot(3'd1, 3'd2);
        for (int i = 0; i < 14; i++) step();
        chk("to.still_waiting", 8'(estado), 8'd4);
        chk("to.no_flag_yet", 8'(erro_timeout), 8'd0);
        step();
        $display("timeout estado=%0d erro=%0d vez=%0d", estado, erro_timeout, jogador_vez);
        chk("to.estado", 8'(estado), 8'd3);
        chk("to.erro", 8'(erro_timeout), 8'd1);
        chk("to.vez", 8'(jogador_vez), 8'd0);
        chk("to.p1", 8'(acertos_p1), 8'd1);
        chk("to.p2", 8'(acertos_p2), 8'd0);

        // P1 misses
        shoot(3'd0, 3'd0);
        answer(1, 1'b0);
        chk("m1.vez", 8'(jogador_vez), 8'd1);
        chk("m1.p1", 8'(acertos_p1), 8'd1);

        // P2 hit arriving on the expiry cycle: col_ready wins
        shoot(3'd4, 3'd4);
        answer(14, 1'b1);
        chk("bd.p2", 8'(acertos_p2), 8'd1);
        chk("bd.estado", 8'(estado), 8'd3);
        chk("bd.vez", 8'(jogador_vez), 8'd0);

        // P1 misses, P2 scores the winning hit
        shoot(3'd2, 3'd2);
        answer(0, 1'b0);
        shoot(3'd6, 3'd1);
        answer(2, 1'b1);
        chk("win.estado", 8'(estado), 8'd5);
        chk("win.fim", 8'(fim), 8'd1);
        chk("win.vencedor", 8'(vencedor), 8'd1);
        chk("win.p2", 8'(acertos_p2), 8'd2);
        chk("win.jogo_enable", 8'(jogo_enable), 8'd0);
        shoot(3'd5, 3'd5);
        chk("win.tiro_ignored", 8'(estado), 8'd5);
        chk("win.no_col_enable", 8'(col_enable), 8'd0);

        // Power off keeps scores
        on = 1'b0;
        step();
        chk("off.estado", 8'(estado), 8'd0);
        chk("off.fim", 8'(fim), 8'd0);
        chk("off.p2_kept", 8'(acertos_p2), 8'd2);

        // Mode 1 match; power off once during P2 placement
        on = 1'b1; mode = 1'b1;
        step();
        chk("m1on.p2_cleared", 8'(acertos_p2), 8'd0);
        chk("m1on.erro_cleared", 8'(erro_timeout), 8'd0);
        place();
        on = 1'b0;
        step();
        chk("offp2.estado", 8'(estado), 8'd0);
        on = 1'b1;
        step();
        mode = 1'b0;
        place();
        place();
        chk("m1.ag", 8'(estado), 8'd3);
        shoot(3'd1, 3'd1);
        answer(0, 1'b1);
        chk("m1.hit_keeps_turn", 8'(jogador_vez), 8'd0);
        chk("m1.p1", 8'(acertos_p1), 8'd1);
        shoot(3'd1, 3'd6);
        answer(0, 1'b0);
        chk("m1.miss_toggles", 8'(jogador_vez), 8'd1);

        // Reset in the middle of a shot
        shoot(3'd7, 3'd3);
        chk("mid.estado", 8'(estado), 8'd4);
        reset = 1'b1;
        step();
        reset = 1'b0; on = 1'b0;
        chk_zero("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
